// File: rtl/distribuidor_carriles_pkg.sv
// Shared definitions for the lane striper: lane count, byte width,
// pointer/counter widths and the two-state FSM encoding.
package distribuidor_carriles_pkg;

   localparam int NUM_LANES = 4;
   localparam int DATA_W    = 8;
   localparam int PTR_W     = 2;
   localparam int CNT_W     = 4;

   typedef logic [DATA_W-1:0] byte_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/distribuidor_carriles_if.sv
// Bus bundle between the byte source and the lane striper.
// With DISTRIBUIDOR_PARIDAD_EN defined an extra per-lane parity vector is carried.
interface distribuidor_carriles_if;
   import distribuidor_carriles_pkg::*;

   byte_t data_in;
   logic  valid_in;
   byte_t data_in0;
   byte_t data_in1;
   byte_t data_in2;
   byte_t data_in3;
   logic  valid0;
   logic  valid1;
   logic  valid2;
   logic  valid3;
   logic  IDL;
`ifdef DISTRIBUIDOR_PARIDAD_EN
   logic [NUM_LANES-1:0] par;

   modport master (output data_in, valid_in,
                   input  data_in0, data_in1, data_in2, data_in3,
                   input  valid0, valid1, valid2, valid3, IDL, par);
   modport slave  (input  data_in, valid_in,
                   output data_in0, data_in1, data_in2, data_in3,
                   output valid0, valid1, valid2, valid3, IDL, par);
`else
   modport master (output data_in, valid_in,
                   input  data_in0, data_in1, data_in2, data_in3,
                   input  valid0, valid1, valid2, valid3, IDL);
   modport slave  (input  data_in, valid_in,
                   output data_in0, data_in1, data_in2, data_in3,
                   output valid0, valid1, valid2, valid3, IDL);
`endif

endinterface

// File: rtl/distribuidor_carriles_contador.sv
// Idle-run counter for the lane striper: counts consecutive empty cycles
// and flags the cycle on which the run reaches IDLE_LIMIT-1.
module contador_inactividad
   import distribuidor_carriles_pkg::*;
#(
   parameter int IDLE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;

   // Clear wins over increment so an accepted byte always restarts the run
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tc = (cnt_q == CNT_W'(IDLE_LIMIT - 1));

endmodule

// File: rtl/distribuidor_carriles.sv
// Byte-to-lane striper: collects a serial byte stream into 4-byte words,
// emitting full words or a partial flush after IDLE_LIMIT empty cycles.
// Optional feature macro: DISTRIBUIDOR_PARIDAD_EN adds a per-lane parity output.
module distribuidor_carriles
   import distribuidor_carriles_pkg::*;
#(
   parameter int IDLE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   distribuidor_carriles_if.slave  bus
);

   state_t               state_q;
   state_t               state_d;
   logic [PTR_W-1:0]     ptr_q;
   byte_t                lane_q      [NUM_LANES-1];
   byte_t                out_data_q  [NUM_LANES];
   byte_t                out_data_d  [NUM_LANES];
   logic [NUM_LANES-1:0] out_valid_q;
   logic [NUM_LANES-1:0] out_valid_d;
   logic                 word_done;
   logic                 flush;
   logic                 cnt_clear;
   logic                 cnt_inc;
   logic                 cnt_tc;

   // The last lane never needs storage: the byte landing there is emitted the same edge
   assign word_done = bus.valid_in && (ptr_q == PTR_W'(NUM_LANES - 1));
   assign cnt_inc   = (state_q == ACTIVE) && !bus.valid_in;
   assign flush     = cnt_inc && cnt_tc;
   assign cnt_clear = (state_q == IDLE) || bus.valid_in || flush;

   contador_inactividad #(
      .IDLE_LIMIT (IDLE_LIMIT)
   ) u_contador (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .tc    (cnt_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: first byte wakes the link, an idle timeout puts it back to sleep
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.valid_in) state_d = ACTIVE;
         ACTIVE:  if (flush)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the next edge: full word, partial flush, or all-zero
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         out_data_d[i] = '0;
      end
      out_valid_d = '0;
      if (word_done) begin
         for (int i = 0; i < NUM_LANES - 1; i++) begin
            out_data_d[i] = lane_q[i];
         end
         out_data_d[NUM_LANES-1] = bus.data_in;
         out_valid_d             = '1;
      end else if (flush) begin
         for (int i = 0; i < NUM_LANES - 1; i++) begin
            if (PTR_W'(i) < ptr_q) begin
               out_data_d[i]  = lane_q[i];
               out_valid_d[i] = 1'b1;
            end
         end
      end
   end

   // Lane storage, pointer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         out_valid_q <= '0;
         for (int i = 0; i < NUM_LANES - 1; i++) begin
            lane_q[i] <= '0;
         end
         for (int i = 0; i < NUM_LANES; i++) begin
            out_data_q[i] <= '0;
         end
      end else begin
         if (bus.valid_in) begin
            ptr_q <= ptr_q + PTR_W'(1);
         end else if (flush) begin
            ptr_q <= '0;
         end
         for (int i = 0; i < NUM_LANES - 1; i++) begin
            if (bus.valid_in && (ptr_q == PTR_W'(i))) begin
               lane_q[i] <= bus.data_in;
            end
         end
         out_valid_q <= out_valid_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            out_data_q[i] <= out_data_d[i];
         end
      end
   end

   assign bus.data_in0 = out_data_q[0];
   assign bus.data_in1 = out_data_q[1];
   assign bus.data_in2 = out_data_q[2];
   assign bus.data_in3 = out_data_q[3];
   assign bus.valid0   = out_valid_q[0];
   assign bus.valid1   = out_valid_q[1];
   assign bus.valid2   = out_valid_q[2];
   assign bus.valid3   = out_valid_q[3];
   assign bus.IDL      = (state_q == IDLE);

`ifdef DISTRIBUIDOR_PARIDAD_EN
   logic [NUM_LANES-1:0] par_q;

   // Parity follows the registered lane bytes; zeroed lanes give zero parity
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            par_q[i] <= ^out_data_d[i];
         end
      end
   end

   assign bus.par = par_q;
`endif

endmodule

// File: tb/tb_distribuidor_carriles.sv
// Self-checking bench for distribuidor_carriles: directed scenarios plus a
// randomized run, all checked against a word-collecting reference model.
// Define DISTRIBUIDOR_PARIDAD_EN to also exercise the parity output.
module tb_distribuidor_carriles;

   localparam int LIMIT = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   distribuidor_carriles_if bus ();

   distribuidor_carriles #(
      .IDLE_LIMIT (LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] obs_data [4];
   logic [3:0] obs_valid;
   assign obs_data[0] = bus.data_in0;
   assign obs_data[1] = bus.data_in1;
   assign obs_data[2] = bus.data_in2;
   assign obs_data[3] = bus.data_in3;
   assign obs_valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

   // Reference model: the partial word as a queue plus the length of the current empty run
   logic [7:0] word_q [$];
   bit         active;
   int         idle_run;
   logic [7:0] exp_data [4];
   logic [3:0] exp_valid;
   logic       exp_idl;

   task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d);
      reset        = rst;
      bus.valid_in = v;
      bus.data_in  = d;
      @(posedge clk);
      #1;
      exp_valid = '0;
      for (int i = 0; i < 4; i++) exp_data[i] = 8'h00;
      if (rst) begin
         word_q.delete();
         active   = 0;
         idle_run = 0;
      end else if (v) begin
         word_q.push_back(d);
         active   = 1;
         idle_run = 0;
         if (word_q.size() == 4) begin
            for (int i = 0; i < 4; i++) exp_data[i] = word_q[i];
            exp_valid = 4'hF;
            word_q.delete();
         end
      end else if (active) begin
         idle_run++;
         if (idle_run == LIMIT) begin
            for (int i = 0; i < word_q.size(); i++) begin
               exp_data[i]  = word_q[i];
               exp_valid[i] = 1'b1;
            end
            word_q.delete();
            active   = 0;
            idle_run = 0;
         end
      end
      exp_idl = !active;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 1'b1, 8'hC3);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data[i] !== 8'h00 || obs_valid[i] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL reset_lane%0d: actual data=%h valid=%b required data=00 valid=0", i, obs_data[i], obs_valid[i]);
            end
         end
         checks++;
         if (bus.IDL !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_idl: actual=%b required=1", bus.IDL);
         end
      end
   endtask

   task automatic test_full_word();
      logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b1, seq[c]);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_valid[i] !== exp_valid[i]) begin
               errors++;
               $display("[TB] FAIL full_word c%0d lane%0d: actual %h/%b required %h/%b", c, i, obs_data[i], obs_valid[i], exp_data[i], exp_valid[i]);
            end
         end
      end
      checks++;
      if ({obs_data[3], obs_data[2], obs_data[1], obs_data[0]} !== 32'h44332211 || obs_valid !== 4'hF || bus.IDL !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_word_const: actual %h%h%h%h v=%b idl=%b required 44332211 v=1111 idl=0", obs_data[3], obs_data[2], obs_data[1], obs_data[0], obs_valid, bus.IDL);
      end
   endtask

   task automatic test_flush();
      logic [7:0] seq [6] = '{8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, c < 2, seq[c]);
         checks++;
         if (obs_valid !== exp_valid || bus.IDL !== exp_idl) begin
            errors++;
            $display("[TB] FAIL flush c%0d: actual v=%b idl=%b required v=%b idl=%b", c, obs_valid, bus.IDL, exp_valid, exp_idl);
         end
      end
      checks++;
      if (obs_data[0] !== 8'hA1 || obs_data[1] !== 8'hA2 || obs_data[2] !== 8'h00 || obs_data[3] !== 8'h00 || obs_valid !== 4'b0011 || bus.IDL !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_const: actual %h %h %h %h v=%b idl=%b required a1 a2 00 00 v=0011 idl=1", obs_data[0], obs_data[1], obs_data[2], obs_data[3], obs_valid, bus.IDL);
      end
   endtask

   task automatic test_back_to_back();
      int words;
      words = 0;
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b0, c < 8, 8'(c + 1));
         if (obs_valid == 4'hF) words++;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_valid[i] !== exp_valid[i]) begin
               errors++;
               $display("[TB] FAIL back_to_back c%0d lane%0d: actual %h/%b required %h/%b", c, i, obs_data[i], obs_valid[i], exp_data[i], exp_valid[i]);
            end
         end
         checks++;
         if (bus.IDL !== exp_idl) begin
            errors++;
            $display("[TB] FAIL back_to_back_idl c%0d: actual=%b required=%b", c, bus.IDL, exp_idl);
         end
      end
      checks++;
      if (words !== 2) begin
         errors++;
         $display("[TB] FAIL back_to_back_words: actual=%0d required=2", words);
      end
   endtask

   task automatic test_timeout_priority();
      bit         vs  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
      logic [7:0] seq [9] = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b0, vs[c], seq[c]);
         checks++;
         if (obs_valid !== exp_valid || bus.IDL !== exp_idl) begin
            errors++;
            $display("[TB] FAIL timeout_priority c%0d: actual v=%b idl=%b required v=%b idl=%b", c, obs_valid, bus.IDL, exp_valid, exp_idl);
         end
      end
      checks++;
      if (obs_data[0] !== 8'h55 || obs_data[1] !== 8'h66 || obs_valid !== 4'b0011) begin
         errors++;
         $display("[TB] FAIL timeout_priority_const: actual %h %h v=%b required 55 66 v=0011", obs_data[0], obs_data[1], obs_valid);
      end
   endtask

   task automatic test_reset_mid_word();
      bit         rs  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
      bit         vs  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      logic [7:0] seq [8] = '{8'h77, 8'h88, 8'hEE, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(rs[c], vs[c], seq[c]);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_valid[i] !== exp_valid[i]) begin
               errors++;
               $display("[TB] FAIL reset_mid_word c%0d lane%0d: actual %h/%b required %h/%b", c, i, obs_data[i], obs_valid[i], exp_data[i], exp_valid[i]);
            end
         end
         checks++;
         if (bus.IDL !== exp_idl) begin
            errors++;
            $display("[TB] FAIL reset_mid_word_idl c%0d: actual=%b required=%b", c, bus.IDL, exp_idl);
         end
      end
      checks++;
      if (obs_data[0] !== 8'h99 || obs_valid !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_mid_word_const: actual %h v=%b required 99 v=0001", obs_data[0], obs_valid);
      end
   endtask

   task automatic test_random();
      int pct;
      pct = 90;
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) pct = (pct == 90) ? 30 : 90;
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < pct, 8'($urandom));
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_valid[i] !== exp_valid[i]) begin
               errors++;
               $display("[TB] FAIL random c%0d lane%0d: actual %h/%b required %h/%b", c, i, obs_data[i], obs_valid[i], exp_data[i], exp_valid[i]);
            end
         end
         checks++;
         if (bus.IDL !== exp_idl) begin
            errors++;
            $display("[TB] FAIL random_idl c%0d: actual=%b required=%b", c, bus.IDL, exp_idl);
         end
      end
   endtask

`ifdef DISTRIBUIDOR_PARIDAD_EN
   task automatic test_parity();
      logic [7:0] seq [4] = '{8'h01, 8'h03, 8'h07, 8'hFF};
      logic [3:0] exp_par;
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b1, seq[c]);
         for (int i = 0; i < 4; i++) exp_par[i] = ^exp_data[i];
         checks++;
         if (bus.par !== exp_par) begin
            errors++;
            $display("[TB] FAIL parity c%0d: actual=%b required=%b", c, bus.par, exp_par);
         end
      end
      checks++;
      if (bus.par !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL parity_const: actual=%b required=0101", bus.par);
      end
   endtask
`endif

   // Scenario sequence
   initial begin
      checks       = 0;
      errors       = 0;
      active       = 0;
      idle_run     = 0;
      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = 8'h00;
      test_reset();
      test_full_word();
      test_flush();
      test_back_to_back();
      test_timeout_priority();
      test_reset_mid_word();
`ifdef DISTRIBUIDOR_PARIDAD_EN
      test_parity();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/distribuidor_carriles.md
DISTRIBUIDOR_CARRILES -- requirements
Module: distribuidor_carriles

Interface
REQ-001 Parameter IDLE_LIMIT, default 4, meaning consecutive empty input cycles in ACTIVE before flush/idle; legal range 1..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 data_in  input  8  serial byte stream from source.
REQ-005 valid_in  input  1  data_in valid this cycle; no backpressure, every valid byte is accepted.
REQ-006 data_in0..data_in3  output  8 each  striped lane bytes, registered.
REQ-007 valid0..valid3  output  1 each  per-lane valid, registered, one-cycle pulse.
REQ-008 IDL  output  1  link idle indicator for the downstream recirculation stage.

Function
REQ-009 Block SHALL have states IDLE and ACTIVE, a 2-bit lane pointer, and an idle counter.
REQ-010 IDL SHALL be 1 exactly while state is IDLE, registered with the outputs.
REQ-011 IDLE with valid_in=1 SHALL store data_in in lane 0, set pointer=1, and go to ACTIVE; IDLE with valid_in=0 SHALL hold.
REQ-012 ACTIVE with valid_in=1 SHALL store data_in in lane[pointer], increment pointer mod 4, and clear the idle counter.
REQ-013 When the byte is stored at pointer=3, all four lanes SHALL appear on data_in0..3 with valid0..3=1 on the next cycle (1-cycle latency), pointer wraps to 0, and state stays ACTIVE.
REQ-014 ACTIVE with valid_in=0 SHALL increment the idle counter.
REQ-015 On the cycle with valid_in=0 and idle counter = IDLE_LIMIT-1, the next cycle SHALL flush: lanes 0..pointer-1 output with their valid=1, remaining lanes have valid=0. State goes to IDLE, and pointer and counter clear.
REQ-016 Flush with pointer=0 SHALL emit no valid and only enter IDLE.
REQ-017 valid_in=1 on the would-be timeout cycle SHALL take priority: the byte is accepted, the counter clears, and no flush occurs.
REQ-018 Any data_inN with its validN=0 SHALL be driven 8'h00.
REQ-019 Output bytes SHALL preserve order: the first accepted byte goes to lane 0 and the fourth to lane 3.

Reset
REQ-020 Reset SHALL force state IDLE, IDL=1, pointer=0, counter=0, all validN=0, and all data_inN=8'h00.
REQ-021 Reset mid-word SHALL discard the partial word without a flush; reset takes priority over valid_in.

Configuration
REQ-022 Macro DISTRIBUIDOR_PARIDAD_EN defined SHALL add output par  output  4  with par[N] equal to the even parity (XOR) of data_inN, registered with it, and 0 when validN=0.
REQ-023 Without DISTRIBUIDOR_PARIDAD_EN, the par port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-024 The shared definitions include SHALL hold NUM_LANES=4, DATA_W=8, and the IDLE/ACTIVE state encodings.
REQ-025 The idle counter with terminal-count detect SHALL be a sub-module named contador_inactividad; lane registers and FSM stay in the top level.

Verification
REQ-026 The bench SHALL apply reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles; required response is data_in0..3=11,22,33,44, all valids=1 one cycle after 0x44, and IDL=0.
REQ-027 The bench SHALL send 0xA1,0xA2 then hold valid_in=0 for 4 cycles (IDLE_LIMIT=4); required response is a flush with lanes 0,1=A1,A2, valid0/1=1, valid2/3=0, data_in2/3=00, and IDL rising the same cycle.
REQ-028 The bench SHALL send 8 back-to-back bytes 0x01..0x08; required response is two full words on cycles 5 and 9 with no IDL assertion.
REQ-029 The bench SHALL send 0x55, 3 idle cycles, then 0x66 on the 4th cycle; required response is no flush and 0x55,0x66 held in lanes 0,1.
REQ-030 The bench SHALL assert reset after 0x77,0x88 are accepted; required response is no valid output, IDL=1, and the next byte 0x99 landing in lane 0.
REQ-031 With DISTRIBUIDOR_PARIDAD_EN defined, the bench SHALL send the word 0x01,0x03,0x07,0xFF; required response is par=4'b0101 (lane0=1, lane1=0, lane2=1, lane3=0).
